cia_timer_ab: RTL and testbench

Dual 16-bit interval timer (Timer A / Timer B) with interrupt control for the CIA area of the chipset. Sits directly downstream of the clock generator on the `clk_28` domain: it counts E-clock ticks, taking the 0.709 MHz E-clock phase and the 7 MHz enable as inputs. It exposes a byte-wide register port to the CPU bus and produces a level interrupt plus per-timer underflow pulses.

---
 rtl/cia_timer_ab.sv | 136 +++++++++++++
 tb/tb_cia_timer_ab.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cia_timer_ab.sv
// Dual 16-bit CIA interval timer (A/B) with ICR interrupt logic and byte register port.
// Timer B can cascade on Timer A underflow within the same clk_28 cycle.
module cia_timer_ab #(
    parameter logic [15:0] TA_RESET = 16'hFFFF,
    parameter logic [15:0] TB_RESET = 16'hFFFF
) (
    input  logic       clk_28,
    input  logic       rst,
    input  logic       clk7_en,
    input  logic       eclk_tick,
    input  logic       sel,
    input  logic       we,
    input  logic [3:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       irq,
    output logic       ta_uf,
    output logic       tb_uf
);

    logic [15:0] ta_latch, ta_cnt, tb_latch, tb_cnt;
    logic [7:0]  cra, crb;
    logic [1:0]  flags, mask;

    logic        ev, wr, rd;
    logic        wr_talo, wr_tahi, wr_tblo, wr_tbhi, wr_icr, wr_cra, wr_crb, rd_icr;
    logic        load_a, load_b, tick_a, tick_b, uf_a, uf_b;
    logic [1:0]  flags_next, mask_next;
    logic [7:0]  rd_data;

    assign ev      = eclk_tick & clk7_en;
    assign wr      = sel & clk7_en & we;
    assign rd      = sel & clk7_en & ~we;
    assign wr_talo = wr & (addr == 4'h4);
    assign wr_tahi = wr & (addr == 4'h5);
    assign wr_tblo = wr & (addr == 4'h6);
    assign wr_tbhi = wr & (addr == 4'h7);
    assign wr_icr  = wr & (addr == 4'hD);
    assign wr_cra  = wr & (addr == 4'hE);
    assign wr_crb  = wr & (addr == 4'hF);
    assign rd_icr  = rd & (addr == 4'hD);

    // Loads take priority over ticks; a CRA/CRB write clearing START suppresses that tick.
    assign load_a = (wr_cra & data_in[4]) | (wr_tahi & ~cra[0]);
    assign tick_a = ev & cra[0] & ~(wr_cra & ~data_in[0]);
    assign uf_a   = tick_a & ~load_a & (ta_cnt == 16'd0);

    assign load_b = (wr_crb & data_in[4]) | (wr_tbhi & ~crb[0]);
    assign tick_b = (crb[6] ? uf_a : ev) & crb[0] & ~(wr_crb & ~data_in[0]);
    assign uf_b   = tick_b & ~load_b & (tb_cnt == 16'd0);

    always_comb begin
        flags_next = (rd_icr ? 2'b00 : flags) | {uf_b, uf_a};
        mask_next  = mask;
        if (wr_icr) begin
            if (data_in[7])
                mask_next = mask | data_in[1:0];
            else
                mask_next = mask & ~data_in[1:0];
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (addr)
            4'h4:    rd_data = ta_cnt[7:0];
            4'h5:    rd_data = ta_cnt[15:8];
            4'h6:    rd_data = tb_cnt[7:0];
            4'h7:    rd_data = tb_cnt[15:8];
            4'hD:    rd_data = {irq, 5'b00000, flags};
            4'hE:    rd_data = cra;
            4'hF:    rd_data = crb;
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk_28 or posedge rst) begin
        if (rst) begin
            ta_latch <= TA_RESET;
            ta_cnt   <= TA_RESET;
            tb_latch <= TB_RESET;
            tb_cnt   <= TB_RESET;
            cra      <= 8'h00;
            crb      <= 8'h00;
            flags    <= 2'b00;
            mask     <= 2'b00;
            data_out <= 8'h00;
            irq      <= 1'b0;
            ta_uf    <= 1'b0;
            tb_uf    <= 1'b0;
        end else begin
            if (wr_talo) ta_latch[7:0]  <= data_in;
            if (wr_tahi) ta_latch[15:8] <= data_in;
            if (wr_tblo) tb_latch[7:0]  <= data_in;
            if (wr_tbhi) tb_latch[15:8] <= data_in;

            if (wr_tahi & ~cra[0])
                ta_cnt <= {data_in, ta_latch[7:0]};
            else if (load_a | uf_a)
                ta_cnt <= ta_latch;
            else if (tick_a)
                ta_cnt <= ta_cnt - 16'd1;

            if (wr_tbhi & ~crb[0])
                tb_cnt <= {data_in, tb_latch[7:0]};
            else if (load_b | uf_b)
                tb_cnt <= tb_latch;
            else if (tick_b)
                tb_cnt <= tb_cnt - 16'd1;

            // LOAD (bit 4) is a strobe and is never stored.
            if (wr_cra)
                cra <= data_in & 8'hEF;
            else if (wr_tahi & ~cra[0] & cra[3])
                cra[0] <= 1'b1;
            else if (uf_a & cra[3])
                cra[0] <= 1'b0;

            if (wr_crb)
                crb <= data_in & 8'hEF;
            else if (wr_tbhi & ~crb[0] & crb[3])
                crb[0] <= 1'b1;
            else if (uf_b & crb[3])
                crb[0] <= 1'b0;

            flags <= flags_next;
            mask  <= mask_next;
            irq   <= |(flags_next & mask_next);
            ta_uf <= uf_a;
            tb_uf <= uf_b;

            if (rd) data_out <= rd_data;
        end
    end

endmodule

// File: tb/tb_cia_timer_ab.sv
// Scoreboard bench for cia_timer_ab: reads push expected bytes, a monitor pops and compares.
module tb_cia_timer_ab;

    logic       clk_28 = 1'b0;
    logic       rst = 1'b1;
    logic       clk7_en = 1'b0;
    logic       eclk_tick = 1'b0;
    logic       sel = 1'b0;
    logic       we = 1'b0;
    logic [3:0] addr = 4'h0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       irq, ta_uf, tb_uf;

    int checks = 0;
    int errors = 0;
    int ta_n = 0, tb_n = 0, both_n = 0;
    logic [7:0] exp_q[$];
    string      name_q[$];
    logic       rd_seen = 1'b0;

    cia_timer_ab dut (
        .clk_28(clk_28), .rst(rst), .clk7_en(clk7_en), .eclk_tick(eclk_tick),
        .sel(sel), .we(we), .addr(addr), .data_in(data_in),
        .data_out(data_out), .irq(irq), .ta_uf(ta_uf), .tb_uf(tb_uf)
    );

    always #5 clk_28 = ~clk_28;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a read issued on a qualifying edge is valid at the next negedge.
    always @(posedge clk_28) rd_seen <= sel & ~we & clk7_en;

    always @(negedge clk_28) begin
        ta_n   += int'(ta_uf);
        tb_n   += int'(tb_uf);
        both_n += int'(ta_uf & tb_uf);
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read", 16'(data_out), 16'hDEAD);
            end else begin
                check(name_q.pop_front(), 16'(data_out), 16'(exp_q.pop_front()));
            end
        end
    end

    task automatic slot(input logic s, input logic w, input logic [3:0] a,
                        input logic [7:0] d, input logic t);
        @(negedge clk_28);
        sel = s; we = w; addr = a; data_in = d; eclk_tick = t; clk7_en = 1'b1;
        @(negedge clk_28);
        clk7_en = 1'b0; sel = 1'b0; we = 1'b0;
        repeat (2) @(negedge clk_28);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic t = 1'b0);
        slot(1'b1, 1'b1, a, d, t);
    endtask

    task automatic rd(input string n, input logic [3:0] a, input logic [7:0] e,
                      input logic t = 1'b0);
        exp_q.push_back(e);
        name_q.push_back(n);
        slot(1'b1, 1'b0, a, 8'h00, t);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) slot(1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
    endtask

    int base_a, base_b, base_c;
    logic [7:0] cont_exp [9] = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'h03};

    initial begin
        repeat (3) @(negedge clk_28);
        rst = 1'b0;
        check("rst_irq", 16'(irq), 16'h0);
        check("rst_data_out", 16'(data_out), 16'h00);
        rd("rst_talo", 4'h4, 8'hFF);
        rd("rst_tahi", 4'h5, 8'hFF);
        rd("rst_cra", 4'hE, 8'h00);

        // Continuous Timer A, latch 3
        wr(4'h4, 8'h03);
        wr(4'h5, 8'h00);
        wr(4'hE, 8'h01);
        base_a = ta_n;
        for (int i = 0; i < 9; i++) rd("cont_talo", 4'h4, cont_exp[i], 1'b1);
        check("cont_uf_count", 16'(ta_n - base_a), 16'd2);
        check("cont_tb_uf", 16'(tb_n), 16'd0);
        wr(4'hE, 8'h00);

        // One-shot with auto-start on TAHI write
        wr(4'hE, 8'h08);
        wr(4'h4, 8'h02);
        wr(4'h5, 8'h00);
        rd("os_cra_started", 4'hE, 8'h09);
        base_a = ta_n;
        tick(5);
        check("os_uf_count", 16'(ta_n - base_a), 16'd1);
        rd("os_cra_stopped", 4'hE, 8'h08);
        rd("os_talo", 4'h4, 8'h02);
        rd("os_icr_flags", 4'hD, 8'h01);
        rd("os_icr_clear", 4'hD, 8'h00);

        // Interrupt: mask TA, underflow, read-to-clear
        wr(4'hD, 8'h81);
        wr(4'h4, 8'h00);
        wr(4'h5, 8'h00);
        check("int_irq_before", 16'(irq), 16'h0);
        tick(1);
        check("int_irq_set", 16'(irq), 16'h1);
        rd("int_icr_read1", 4'hD, 8'h81);
        check("int_irq_cleared", 16'(irq), 16'h0);
        rd("int_icr_read2", 4'hD, 8'h00);

        // Collision: ICR read on the underflow edge
        wr(4'h5, 8'h00);
        rd("col_icr_old", 4'hD, 8'h00, 1'b1);
        check("col_irq_set", 16'(irq), 16'h1);
        rd("col_icr_next", 4'hD, 8'h81);
        rd("col_icr_clear", 4'hD, 8'h00);

        // Cascade: TA latch 1 continuous, TB latch 2 counting TA underflows
        wr(4'hE, 8'h00);
        wr(4'h4, 8'h01);
        wr(4'h5, 8'h00);
        wr(4'h6, 8'h02);
        wr(4'h7, 8'h00);
        wr(4'hF, 8'h41);
        wr(4'hE, 8'h01);
        base_a = ta_n; base_b = tb_n; base_c = both_n;
        tick(12);
        check("casc_ta_uf", 16'(ta_n - base_a), 16'd6);
        check("casc_tb_uf", 16'(tb_n - base_b), 16'd2);
        check("casc_coincident", 16'(both_n - base_c), 16'd2);
        rd("casc_tblo", 4'h6, 8'h02);

        // LOAD strobe beats a same-cycle tick; CRA write clearing START drops the tick
        wr(4'h4, 8'h05);
        wr(4'hE, 8'h11, 1'b1);
        rd("load_talo", 4'h4, 8'h05);
        rd("load_cra", 4'hE, 8'h01);
        wr(4'hE, 8'h00, 1'b1);
        rd("stop_talo", 4'h4, 8'h05);

        // Reset mid-count
        wr(4'hE, 8'h01);
        tick(2);
        rd("pre_rst_talo", 4'h4, 8'h03);
        check("pre_rst_irq", 16'(irq), 16'h1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_irq", 16'(irq), 16'h0);
        check("mid_rst_cra", 16'(dut.cra), 16'h00);
        #2 rst = 1'b0;
        base_a = ta_n;
        rd("post_rst_talo", 4'h4, 8'hFF);
        rd("post_rst_tahi", 4'h5, 8'hFF);
        rd("post_rst_cra", 4'hE, 8'h00);
        rd("post_rst_icr", 4'hD, 8'h00);
        tick(3);
        rd("post_rst_no_count", 4'h4, 8'hFF);
        rd("unmapped_read", 4'h2, 8'h00);
        check("post_rst_no_uf", 16'(ta_n - base_a), 16'd0);

        repeat (4) @(negedge clk_28);
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
